autoconfig_chain: RTL and testbench

- Parametrised Zorro II AutoConfig responder for a daisy chain of NUM_CARDS logical boards on the accelerator.
- Sits between the 68030-side bus (AS/DS/RW/A/D) and the board's memory/peripheral decoders.
- Unlike the fixed two-card design, it is CLK-synchronous and takes per-card ROM contents as parameters.
- It latches the base address the OS actually writes and decodes each card by its latched base and ER_TYPE size.

---
 rtl/autoconfig_pkg.sv | 29 ++
 rtl/autoconfig_chain_if.sv | 18 +
 rtl/autoconfig_rom.sv | 57 +++++
 rtl/autoconfig_chain.sv | 151 +++++++++++++++
 tb/tb_autoconfig_chain.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/autoconfig_pkg.sv
// Shared constants and helpers for the AutoConfig responder chain.
//   - Zorro II config-space base and the register offsets (in zaddr units, A[6:1])
//   - size_mask(): converts an er_Type size code into the mask used on A[23:16]
package autoconfig_pkg;

    localparam logic [15:0] CFG_BASE   = 16'h00E8;

    localparam logic [5:0]  ZA_TYPE_HI = 6'h00;
    localparam logic [5:0]  ZA_BASE_HI = 6'h24;
    localparam logic [5:0]  ZA_BASE_LO = 6'h25;
    localparam logic [5:0]  ZA_SHUTUP  = 6'h26;

    // Board size code -> compare mask on A[23:16]; 000 encodes the 8M board.
    function automatic logic [7:0] size_mask(input logic [2:0] code);
        logic [7:0] m;
        case (code)
            3'b001:  m = 8'hFF;
            3'b010:  m = 8'hFE;
            3'b011:  m = 8'hFC;
            3'b100:  m = 8'hF8;
            3'b101:  m = 8'hF0;
            3'b110:  m = 8'hE0;
            3'b111:  m = 8'hC0;
            default: m = 8'h80;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/autoconfig_chain_if.sv
// 68030-side bus as seen by the AutoConfig responder.
//   AS20_n, DS20_n : address / data strobes (asynchronous to CLK)
//   RW20           : 1 = read
//   A, D           : CPU address and data (only D[7:4] carries config data)
//   DOUT, DOUT_OE  : ROM nibble for D[31:28] and its output enable
// master = CPU side, slave = responder.
interface autoconfig_chain_if;
    logic        AS20_n;
    logic        DS20_n;
    logic        RW20;
    logic [31:0] A;
    logic [7:0]  D;
    logic [3:0]  DOUT;
    logic        DOUT_OE;

    modport master (output AS20_n, DS20_n, RW20, A, D, input DOUT, DOUT_OE);
    modport slave  (input AS20_n, DS20_n, RW20, A, D, output DOUT, DOUT_OE);
endinterface

// File: rtl/autoconfig_rom.sv
// AutoConfig ROM image for the card currently being configured.
//   card   : index of the active card in the chain
//   zaddr  : config-space nibble address (A[6:1])
//   nibble : value presented on D[31:28]
// er_Type is returned as-is; all other defined fields are returned inverted,
// and undefined locations read as 4'hF.
module autoconfig_rom
    import autoconfig_pkg::*;
#(
    parameter int                      NUM_CARDS  = 2,
    parameter logic [NUM_CARDS*8-1:0]  ER_TYPE    = {8'he5, 8'hc1},
    parameter logic [NUM_CARDS*8-1:0]  ER_PRODUCT = {8'h08, 8'h0e},
    parameter logic [7:0]              ER_FLAGS   = 8'h00,
    parameter logic [15:0]             MFG_ID     = 16'h0a3c,
    parameter logic [31:0]             SERIAL     = 32'h0000_0001
) (
    input  logic [1:0] card,
    input  logic [5:0] zaddr,
    output logic [3:0] nibble
);

    // Padded to four cards so the byte select is always in range.
    localparam logic [31:0] TYPE_ALL = 32'(ER_TYPE);
    localparam logic [31:0] PROD_ALL = 32'(ER_PRODUCT);

    logic [7:0] sel_type;
    logic [7:0] sel_prod;

    assign sel_type = TYPE_ALL[{card, 3'b000} +: 8];
    assign sel_prod = PROD_ALL[{card, 3'b000} +: 8];

    always_comb begin
        nibble = 4'hF;
        case (zaddr)
            ZA_TYPE_HI: nibble = sel_type[7:4];
            6'h01:      nibble = sel_type[3:0];
            6'h02:      nibble = ~sel_prod[7:4];
            6'h03:      nibble = ~sel_prod[3:0];
            6'h04:      nibble = ~ER_FLAGS[7:4];
            6'h05:      nibble = ~ER_FLAGS[3:0];
            6'h08:      nibble = ~MFG_ID[15:12];
            6'h09:      nibble = ~MFG_ID[11:8];
            6'h0A:      nibble = ~MFG_ID[7:4];
            6'h0B:      nibble = ~MFG_ID[3:0];
            6'h0C:      nibble = ~SERIAL[31:28];
            6'h0D:      nibble = ~SERIAL[27:24];
            6'h0E:      nibble = ~SERIAL[23:20];
            6'h0F:      nibble = ~SERIAL[19:16];
            6'h10:      nibble = ~SERIAL[15:12];
            6'h11:      nibble = ~SERIAL[11:8];
            6'h12:      nibble = ~SERIAL[7:4];
            6'h13:      nibble = ~SERIAL[3:0];
            default:    nibble = 4'hF;
        endcase
    end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II AutoConfig responder for a daisy chain of NUM_CARDS logical boards.
// Synchronous to CLK; the bus strobes are synchronised internally.
//   CLK          : bus-domain clock (>= 4x DS rate)
//   RESET        : asynchronous, active-low
//   bus          : CPU bus (strobes, RW, A, D in; DOUT/DOUT_OE out)
//   CFG_ACCESS_n : low while A hits config space and the chain is not done
//   DECODE_n     : per-card select from the latched base, active-low
//   CFG_DONE     : every card configured or shut up
//
// state | meaning
// IDLE  | card cur awaiting its base-address or shut-up write
// PEND  | card cur written; advance to the next card when AS rises
// DONE  | whole chain handled; config space no longer claimed
module autoconfig_chain
    import autoconfig_pkg::*;
#(
    parameter int                      NUM_CARDS  = 2,
    parameter logic [NUM_CARDS*8-1:0]  ER_TYPE    = {8'he5, 8'hc1},
    parameter logic [NUM_CARDS*8-1:0]  ER_PRODUCT = {8'h08, 8'h0e},
    parameter logic [7:0]              ER_FLAGS   = 8'h00,
    parameter logic [15:0]             MFG_ID     = 16'h0a3c,
    parameter logic [31:0]             SERIAL     = 32'h0000_0001
) (
    input  logic                 CLK,
    input  logic                 RESET,
    autoconfig_chain_if.slave    bus,
    output logic                 CFG_ACCESS_n,
    output logic [NUM_CARDS-1:0] DECODE_n,
    output logic                 CFG_DONE
);

    localparam int CW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [CW-1:0]        cur;
    logic [NUM_CARDS-1:0] configured;
    logic [NUM_CARDS-1:0] shutup;
    logic [7:0]           base [NUM_CARDS];
    logic [3:0]           base_lo;
    logic [3:0]           dout;
    logic                 dout_oe;

    logic [1:0] as_s, ds_s;
    logic       as_d, ds_d;
    logic       as_rise, ds_fall;
    logic       hit, rd_strobe, wr_strobe;
    logic [5:0] zaddr;
    logic [3:0] rom_nibble;
    logic       unused_bits;

    assign as_rise   = ~as_d & as_s[1];
    assign ds_fall   = ds_d & ~ds_s[1];
    assign CFG_DONE  = (state == ST_DONE);
    assign hit       = (bus.A[31:16] == CFG_BASE) & ~CFG_DONE;
    assign zaddr     = bus.A[6:1];
    assign rd_strobe = ds_fall & hit & bus.RW20;
    assign wr_strobe = ds_fall & hit & ~bus.RW20;

    assign CFG_ACCESS_n = ~hit;
    assign bus.DOUT     = dout;
    assign bus.DOUT_OE  = dout_oe;
    assign unused_bits  = ^{bus.A[15:7], bus.A[0], bus.D[3:0]};

    autoconfig_rom #(
        .NUM_CARDS  (NUM_CARDS),
        .ER_TYPE    (ER_TYPE),
        .ER_PRODUCT (ER_PRODUCT),
        .ER_FLAGS   (ER_FLAGS),
        .MFG_ID     (MFG_ID),
        .SERIAL     (SERIAL)
    ) u_rom (
        .card   (2'(cur)),
        .zaddr  (zaddr),
        .nibble (rom_nibble)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // Strobes idle high, so the synchronisers start high to avoid a false edge.
            as_s       <= 2'b11;
            ds_s       <= 2'b11;
            as_d       <= 1'b1;
            ds_d       <= 1'b1;
            state      <= ST_IDLE;
            cur        <= '0;
            configured <= '0;
            shutup     <= '0;
            base_lo    <= 4'h0;
            dout       <= 4'hF;
            dout_oe    <= 1'b0;
            for (int k = 0; k < NUM_CARDS; k++) base[k] <= 8'h00;
        end else begin
            as_s <= {as_s[0], bus.AS20_n};
            ds_s <= {ds_s[0], bus.DS20_n};
            as_d <= as_s[1];
            ds_d <= ds_s[1];

            if (rd_strobe) begin
                dout    <= rom_nibble;
                dout_oe <= 1'b1;
            end else if (as_rise) begin
                dout_oe <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_PEND: begin
                    if (wr_strobe) begin
                        case (zaddr)
                            ZA_BASE_LO: base_lo <= bus.D[7:4];
                            ZA_BASE_HI: begin
                                base[cur]       <= {bus.D[7:4], base_lo};
                                configured[cur] <= 1'b1;
                                state           <= ST_PEND;
                            end
                            ZA_SHUTUP: begin
                                shutup[cur] <= 1'b1;
                                state       <= ST_PEND;
                            end
                            default: ;
                        endcase
                    end else if (as_rise && state == ST_PEND) begin
                        // Advancing only at the end of the bus cycle keeps the
                        // card visible for the whole write that configured it.
                        if (cur == CW'(NUM_CARDS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            cur   <= cur + CW'(1);
                            state <= ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        DECODE_n = '1;
        for (int k = 0; k < NUM_CARDS; k++) begin
            if (configured[k] && !shutup[k] &&
                ((bus.A[23:16] & size_mask(ER_TYPE[k*8 +: 3])) ==
                 (base[k]      & size_mask(ER_TYPE[k*8 +: 3]))))
                DECODE_n[k] = 1'b0;
        end
    end

endmodule

// File: tb/tb_autoconfig_chain.sv
module tb_autoconfig_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_access_n;
    logic [1:0] decode_n;
    logic       cfg_done;

    autoconfig_chain_if bus();

    autoconfig_chain #(.NUM_CARDS(2)) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .bus          (bus),
        .CFG_ACCESS_n (cfg_access_n),
        .DECODE_n     (decode_n),
        .CFG_DONE     (cfg_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_idle();
        bus.AS20_n = 1'b1;
        bus.DS20_n = 1'b1;
        bus.RW20   = 1'b1;
        bus.A      = 32'h0;
        bus.D      = 8'h00;
    endtask

    task automatic bus_start(input logic [5:0] za, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.A      = 32'h00E8_0000 | {25'd0, za, 1'b0};
        bus.RW20   = rw;
        bus.D      = d;
        bus.AS20_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.DS20_n = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] za, input logic [3:0] exp, input string tag);
        exp_q.push_back(exp);
        bus_start(za, 1'b1, 8'h00);
        for (int i = 0; i < 10 && bus.DOUT_OE !== 1'b1; i++) @(negedge clk);
        check({tag, "_oe"}, 32'(bus.DOUT_OE), 32'd1);
        check(tag, 32'(bus.DOUT), 32'(exp_q.pop_front()));
        bus.DS20_n = 1'b1;
        @(negedge clk);
        bus.AS20_n = 1'b1;
        for (int i = 0; i < 10 && bus.DOUT_OE !== 1'b0; i++) @(negedge clk);
        check({tag, "_oe_off"}, 32'(bus.DOUT_OE), 32'd0);
        bus.A = 32'h0;
    endtask

    task automatic do_write(input logic [5:0] za, input logic [7:0] d, input logic keep_as);
        bus_start(za, 1'b0, d);
        repeat (4) @(negedge clk);
        bus.DS20_n = 1'b1;
        repeat (3) @(negedge clk);
        if (!keep_as) begin
            bus.AS20_n = 1'b1;
            repeat (4) @(negedge clk);
            bus.A  = 32'h0;
            bus.RW20 = 1'b1;
        end
    endtask

    task automatic check_decode(input logic [31:0] addr, input logic [1:0] exp, input string tag);
        bus.A = addr;
        #1;
        check(tag, 32'(decode_n), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout",     32'(bus.DOUT),     32'hF);
        check("rst_dout_oe",  32'(bus.DOUT_OE),  32'd0);
        check("rst_done",     32'(cfg_done),     32'd0);
        check("rst_decode",   32'(decode_n),     32'h3);
        check("rst_access",   32'(cfg_access_n), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bus.A = 32'h00E8_0000; #1;
        check("cfg_hit", 32'(cfg_access_n), 32'd0);
        bus.A = 32'h00E9_0000; #1;
        check("cfg_miss", 32'(cfg_access_n), 32'd1);
        bus.A = 32'h0;

        // Card 0 ROM (er_Type c1, product 0e, mfg 0a3c)
        do_read(6'h00, 4'hC, "c0_type_hi");
        do_read(6'h01, 4'h1, "c0_type_lo");
        do_read(6'h02, 4'hF, "c0_prod_hi");
        do_read(6'h03, 4'h1, "c0_prod_lo");
        do_read(6'h08, 4'hF, "c0_mfg0");
        do_read(6'h09, 4'h5, "c0_mfg1");
        do_read(6'h0A, 4'hC, "c0_mfg2");
        do_read(6'h13, 4'hE, "c0_ser7");
        do_read(6'h30, 4'hF, "c0_undef");

        // Configure card 0 at 0x20 (64K)
        do_write(6'h25, 8'h00, 1'b0);
        do_write(6'h24, 8'h20, 1'b0);
        check("c0_done", 32'(cfg_done), 32'd0);
        do_read(6'h00, 4'hE, "c1_type_hi");
        do_read(6'h01, 4'h5, "c1_type_lo");
        do_read(6'h03, 4'h7, "c1_prod_lo");
        check_decode(32'h0020_0000, 2'b10, "dec0_lo");
        check_decode(32'h0020_FFFF, 2'b10, "dec0_hi");
        check_decode(32'h0021_0000, 2'b11, "dec0_above");
        check_decode(32'h001F_FFFF, 2'b11, "dec0_below");

        // Configure card 1 at 0x40 (1M)
        do_write(6'h25, 8'h00, 1'b0);
        do_write(6'h24, 8'h40, 1'b0);
        check("c1_done", 32'(cfg_done), 32'd1);
        check_decode(32'h0040_0000, 2'b01, "dec1_lo");
        check_decode(32'h004F_FFFF, 2'b01, "dec1_hi");
        check_decode(32'h0050_0000, 2'b11, "dec1_above");
        check_decode(32'h0020_1234, 2'b10, "dec0_kept");
        bus_start(6'h00, 1'b1, 8'h00);
        repeat (6) @(negedge clk);
        check("done_access", 32'(cfg_access_n), 32'd1);
        check("done_oe",     32'(bus.DOUT_OE),  32'd0);
        bus.DS20_n = 1'b1;
        bus.AS20_n = 1'b1;
        repeat (3) @(negedge clk);

        // Shut up card 0, configure card 1
        do_reset();
        check("rst2_decode", 32'(decode_n), 32'h3);
        check("rst2_done",   32'(cfg_done), 32'd0);
        do_write(6'h26, 8'h00, 1'b0);
        do_read(6'h00, 4'hE, "su_c1_type");
        do_write(6'h25, 8'h00, 1'b0);
        do_write(6'h24, 8'h40, 1'b0);
        check("su_done", 32'(cfg_done), 32'd1);
        check_decode(32'h0045_0000, 2'b01, "su_dec1");
        check_decode(32'h0000_0000, 2'b11, "su_dec0_a");
        check_decode(32'h0020_0000, 2'b11, "su_dec0_b");

        // Two base writes to card 0 inside one AS cycle
        do_reset();
        do_write(6'h25, 8'h00, 1'b1);
        do_write(6'h24, 8'h20, 1'b1);
        do_write(6'h24, 8'h60, 1'b0);
        check("dbl_done", 32'(cfg_done), 32'd0);
        do_read(6'h00, 4'hE, "dbl_c1_type");
        check_decode(32'h0060_0000, 2'b10, "dbl_dec_new");
        check_decode(32'h0020_0000, 2'b11, "dbl_dec_old");

        // Reset while card 1 write is pending
        do_write(6'h25, 8'h00, 1'b1);
        do_write(6'h24, 8'h40, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.A = 32'h0060_0000;
        #1;
        check("midrst_decode", 32'(decode_n),    32'h3);
        check("midrst_done",   32'(cfg_done),    32'd0);
        check("midrst_dout",   32'(bus.DOUT),    32'hF);
        bus.AS20_n = 1'b1;
        bus.A      = 32'h0;
        bus.RW20   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_done2", 32'(cfg_done), 32'd0);
        do_read(6'h00, 4'hC, "midrst_c0_type");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
